// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the I/D-cache to memory arbiter: bus field positions,
// bus widths, FSM encoding and small packing helpers.
package mem_bus_arbiter_pkg;

    localparam int REQ_W     = 66;
    localparam int RSP_W     = 33;

    localparam int REQ_BIT   = 65;
    localparam int WE_BIT    = 64;
    localparam int ADDR_MSB  = 63;
    localparam int ADDR_LSB  = 32;
    localparam int WDATA_MSB = 31;
    localparam int WDATA_LSB = 0;

    localparam int ACK_BIT   = 32;
    localparam int RDATA_MSB = 31;
    localparam int RDATA_LSB = 0;

    typedef logic [1:0] arb_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_I = 2'd1;
    localparam logic [1:0] ST_GNT_D = 2'd2;

    localparam logic LG_I = 1'b0;
    localparam logic LG_D = 1'b1;

    function automatic logic [REQ_W-1:0] pack_req(input logic        req,
                                                  input logic        we,
                                                  input logic [31:0] addr,
                                                  input logic [31:0] wdata);
        logic [REQ_W-1:0] r;
        r                        = '0;
        r[REQ_BIT]               = req;
        r[WE_BIT]                = we;
        r[ADDR_MSB:ADDR_LSB]     = addr;
        r[WDATA_MSB:WDATA_LSB]   = wdata;
        return r;
    endfunction

    function automatic logic [RSP_W-1:0] pack_rsp(input logic        ack,
                                                  input logic [31:0] rdata);
        logic [RSP_W-1:0] r;
        r                        = '0;
        r[ACK_BIT]               = ack;
        r[RDATA_MSB:RDATA_LSB]   = rdata;
        return r;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_wdog.sv
// Wait-cycle watchdog: counts granted cycles without an ack and flags the
// terminal count one cycle before TIMEOUT_CYCLES granted cycles have elapsed.
module arb_wdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic count_en_i,
    output logic tc_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any cycle that is not a plain wait (idle, ack, abort, timeout) clears the count.
    always_comb begin
        cnt_d = '0;
        if (count_en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter sharing one memory port between the
// I-cache and D-cache, with watchdog abort of stalled transactions.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no owner; memory request bus driven to zero
// GNT_I    | I-cache owns the memory port until ack/abort/timeout
// GNT_D    | D-cache owns the memory port until ack/abort/timeout
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [REQ_W-1:0]  Icache_bus_in,
    output logic [RSP_W-1:0]  Icache_bus_out,
    input  logic [REQ_W-1:0]  Dcache_bus_in,
    output logic [RSP_W-1:0]  Dcache_bus_out,
    output logic [REQ_W-1:0]  Mem_bus_out,
    input  logic [RSP_W-1:0]  Mem_bus_in,
    output logic              o_grant_i,
    output logic              o_grant_d,
    output logic              o_timeout
);

    arb_state_t        state_q, state_d;
    logic              last_q, last_d;
    logic              count_en;
    logic              tc;
    logic              req_i, req_d, ack;
    logic              g_req;
    logic [REQ_W-1:0]  g_bus;
    logic [RSP_W-1:0]  g_rsp;

    assign req_i = Icache_bus_in[REQ_BIT];
    assign req_d = Dcache_bus_in[REQ_BIT];
    assign ack   = Mem_bus_in[ACK_BIT];

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        count_en       = 1'b0;
        o_timeout      = 1'b0;
        g_req          = 1'b0;
        g_bus          = '0;
        g_rsp          = '0;
        Mem_bus_out    = '0;
        Icache_bus_out = '0;
        Dcache_bus_out = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_i && req_d) begin
                    // Tie goes to whoever was not granted last.
                    if (last_q == LG_I) begin
                        state_d = ST_GNT_D;
                        last_d  = LG_D;
                    end else begin
                        state_d = ST_GNT_I;
                        last_d  = LG_I;
                    end
                end else if (req_i) begin
                    state_d = ST_GNT_I;
                    last_d  = LG_I;
                end else if (req_d) begin
                    state_d = ST_GNT_D;
                    last_d  = LG_D;
                end
            end

            ST_GNT_I, ST_GNT_D: begin
                g_req       = (state_q == ST_GNT_D) ? req_d : req_i;
                g_bus       = (state_q == ST_GNT_D) ? Dcache_bus_in : Icache_bus_in;
                Mem_bus_out = g_bus;

                if (!g_req) begin
                    state_d = ST_IDLE;
                end else if (ack) begin
                    g_rsp   = Mem_bus_in;
                    state_d = ST_IDLE;
                end else if (tc) begin
                    g_rsp     = pack_rsp(1'b1, 32'h0);
                    o_timeout = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    g_rsp    = Mem_bus_in;
                    count_en = 1'b1;
                end

                if (state_q == ST_GNT_D) begin
                    Dcache_bus_out = g_rsp;
                end else begin
                    Icache_bus_out = g_rsp;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            last_q  <= LG_I;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    arb_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i      (Clk),
        .rst_ni     (Rst),
        .count_en_i (count_en),
        .tc_o       (tc)
    );

    assign o_grant_i = (state_q == ST_GNT_I);
    assign o_grant_d = (state_q == ST_GNT_D);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed scenarios push expected
// response and grant events; a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int TO = 4;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic [REQ_W-1:0]  ic  = '0;
    logic [REQ_W-1:0]  dc  = '0;
    logic [RSP_W-1:0]  mem = '0;
    logic [RSP_W-1:0]  Icache_bus_out, Dcache_bus_out;
    logic [REQ_W-1:0]  Mem_bus_out;
    logic              o_grant_i, o_grant_d, o_timeout;

    int passed = 0;
    int total  = 0;

    logic [66:0] rsp_q[$];
    logic [1:0]  gnt_q[$];
    logic [1:0]  gnt_prev = 2'b00;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Icache_bus_in  (ic),
        .Icache_bus_out (Icache_bus_out),
        .Dcache_bus_in  (dc),
        .Dcache_bus_out (Dcache_bus_out),
        .Mem_bus_out    (Mem_bus_out),
        .Mem_bus_in     (mem),
        .o_grant_i      (o_grant_i),
        .o_grant_d      (o_grant_d),
        .o_timeout      (o_timeout)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required end before 200000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [66:0] ev(input logic [32:0] ir, input logic [32:0] dr, input logic to);
        return {ir, dr, to};
    endfunction

    always @(negedge Clk) begin
        logic [66:0] e;
        logic [1:0]  g;
        e = {Icache_bus_out, Dcache_bus_out, o_timeout};
        g = {o_grant_i, o_grant_d};
        if (Icache_bus_out[ACK_BIT] || Dcache_bus_out[ACK_BIT] || o_timeout) begin
            if (rsp_q.size() == 0) begin
                total++;
                $display("FAIL rsp_unexpected: got %0h required no response", e);
            end else begin
                check("rsp_event", e, rsp_q.pop_front());
            end
        end
        if (g != gnt_prev) begin
            if (gnt_q.size() == 0) begin
                total++;
                $display("FAIL gnt_unexpected: got %b required no change from %b", g, gnt_prev);
            end else begin
                check("gnt_event", g, gnt_q.pop_front());
            end
            gnt_prev = g;
        end
    end

    initial begin
        // Reset with active-looking inputs: everything must stay quiet.
        Rst = 1'b0;
        ic  = pack_req(1'b1, 1'b1, 32'h0000AAAA, 32'h0000BBBB);
        dc  = pack_req(1'b1, 1'b0, 32'h0000CCCC, 32'h0);
        mem = pack_rsp(1'b1, 32'h12345678);
        repeat (2) @(posedge Clk);
        #1;
        check("rst_mem_bus", Mem_bus_out, 66'h0);
        check("rst_i_rsp", Icache_bus_out, 33'h0);
        check("rst_d_rsp", Dcache_bus_out, 33'h0);
        check("rst_grants", {o_grant_i, o_grant_d, o_timeout}, 3'b000);
        ic = '0; dc = '0; mem = '0;
        tick();
        Rst = 1'b1;
        tick();

        // Single I request, ack at cycle 3.
        gnt_q.push_back(2'b10); gnt_q.push_back(2'b00);
        rsp_q.push_back(ev(pack_rsp(1'b1, 32'hCAFEF00D), 33'h0, 1'b0));
        ic = pack_req(1'b1, 1'b0, 32'h100, 32'h0);
        tick();
        check("A_grant_c1", o_grant_i, 1'b1);
        check("A_mem_bus", Mem_bus_out, ic);
        tick(); tick();
        mem = pack_rsp(1'b1, 32'hCAFEF00D);
        tick();
        check("A_idle_c4_grant", o_grant_i, 1'b0);
        check("A_idle_c4_mem_bus", Mem_bus_out, 66'h0);
        ic = '0; mem = '0;
        tick();

        // Tie after reset: D first, mandatory idle, then I.
        Rst = 1'b0; #1; Rst = 1'b1;
        tick();
        gnt_q.push_back(2'b01); gnt_q.push_back(2'b00);
        gnt_q.push_back(2'b10); gnt_q.push_back(2'b00);
        rsp_q.push_back(ev(33'h0, pack_rsp(1'b1, 32'h11111111), 1'b0));
        rsp_q.push_back(ev(pack_rsp(1'b1, 32'h22222222), 33'h0, 1'b0));
        ic = pack_req(1'b1, 1'b0, 32'h200, 32'h0);
        dc = pack_req(1'b1, 1'b1, 32'h300, 32'hABCD0123);
        tick();
        check("B_grant_d", {o_grant_i, o_grant_d}, 2'b01);
        check("B_mem_bus", Mem_bus_out, dc);
        mem = pack_rsp(1'b0, 32'h99);
        #1;
        check("B_non_granted_rsp", Icache_bus_out, 33'h0);
        check("B_passthru_rsp", Dcache_bus_out, pack_rsp(1'b0, 32'h99));
        tick();
        mem = pack_rsp(1'b1, 32'h11111111);
        tick();
        mem = '0; dc = '0;
        check("B_mandatory_idle", {o_grant_i, o_grant_d}, 2'b00);
        tick();
        check("B_grant_i", o_grant_i, 1'b1);
        mem = pack_rsp(1'b1, 32'h22222222);
        tick();
        ic = '0; mem = '0;
        tick();

        // Timeout: D granted at cycle 1, synthetic response at cycle 4.
        gnt_q.push_back(2'b01); gnt_q.push_back(2'b00);
        rsp_q.push_back(ev(33'h0, pack_rsp(1'b1, 32'h0), 1'b1));
        dc = pack_req(1'b1, 1'b0, 32'h400, 32'h0);
        tick(); tick(); tick();
        check("T_no_timeout_c3", o_timeout, 1'b0);
        tick();
        check("T_timeout_c4", o_timeout, 1'b1);
        tick();
        check("T_idle_c5", {o_grant_d, o_timeout}, 2'b00);
        dc = '0;
        tick();

        // Ack at the terminal wait count: ack wins.
        gnt_q.push_back(2'b01); gnt_q.push_back(2'b00);
        rsp_q.push_back(ev(33'h0, pack_rsp(1'b1, 32'hDEADBEEF), 1'b0));
        dc = pack_req(1'b1, 1'b0, 32'h500, 32'h0);
        tick(); tick(); tick(); tick();
        mem = pack_rsp(1'b1, 32'hDEADBEEF);
        #1;
        check("C_no_timeout", o_timeout, 1'b0);
        tick();
        mem = '0; dc = '0;
        check("C_idle", o_grant_d, 1'b0);
        tick();

        // D was granted last: a tie now goes to I, held D served next.
        gnt_q.push_back(2'b10); gnt_q.push_back(2'b00);
        gnt_q.push_back(2'b01); gnt_q.push_back(2'b00);
        rsp_q.push_back(ev(pack_rsp(1'b1, 32'h33333333), 33'h0, 1'b0));
        rsp_q.push_back(ev(33'h0, pack_rsp(1'b1, 32'h44444444), 1'b0));
        ic = pack_req(1'b1, 1'b0, 32'h600, 32'h0);
        dc = pack_req(1'b1, 1'b0, 32'h700, 32'h0);
        tick();
        check("R_tie_to_i", {o_grant_i, o_grant_d}, 2'b10);
        mem = pack_rsp(1'b1, 32'h33333333);
        tick();
        ic = '0; mem = '0;
        tick();
        check("R_held_d", {o_grant_i, o_grant_d}, 2'b01);
        mem = pack_rsp(1'b1, 32'h44444444);
        tick();
        dc = '0; mem = '0;
        tick();

        // Requester abort: I drops req at cycle 2 while memory acks.
        gnt_q.push_back(2'b10); gnt_q.push_back(2'b00);
        ic = pack_req(1'b1, 1'b0, 32'h800, 32'h0);
        tick(); tick();
        ic = '0;
        mem = pack_rsp(1'b1, 32'h5555);
        #1;
        check("X_abort_rsp", Icache_bus_out, 33'h0);
        check("X_abort_timeout", o_timeout, 1'b0);
        tick();
        check("X_idle_c3", o_grant_i, 1'b0);
        mem = '0;
        tick();

        // Asynchronous reset in GNT_D, then held D regranted.
        gnt_q.push_back(2'b01); gnt_q.push_back(2'b00);
        gnt_q.push_back(2'b01); gnt_q.push_back(2'b00);
        rsp_q.push_back(ev(33'h0, pack_rsp(1'b1, 32'h77), 1'b0));
        dc = pack_req(1'b1, 1'b1, 32'h900, 32'h1);
        tick(); tick();
        mem = pack_rsp(1'b1, 32'h600D);
        Rst = 1'b0;
        #1;
        check("M_rst_grant", {o_grant_i, o_grant_d}, 2'b00);
        check("M_rst_mem_bus", Mem_bus_out, 66'h0);
        check("M_rst_d_rsp", Dcache_bus_out, 33'h0);
        mem = '0;
        tick();
        Rst = 1'b1;
        #1;
        check("M_release_no_grant", o_grant_d, 1'b0);
        tick();
        check("M_regrant", o_grant_d, 1'b1);
        mem = pack_rsp(1'b1, 32'h77);
        tick();
        dc = '0; mem = '0;
        tick(); tick();

        check("rsp_q_drained", rsp_q.size(), 0);
        check("gnt_q_drained", gnt_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of granted cycles without a memory ack before the arbiter aborts the transaction.
REQ-002 Clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Rst  input  1  reset, asynchronous assertion, active-low (Rst=0 resets).
REQ-004 Icache_bus_in  input  66  request from the I-cache.
REQ-005 Icache_bus_out  output  33  response to the I-cache.
REQ-006 Dcache_bus_in  input  66  request from the D-cache.
REQ-007 Dcache_bus_out  output  33  response to the D-cache.
REQ-008 Mem_bus_out  output  66  request to the shared memory port.
REQ-009 Mem_bus_in  input  33  response from the shared memory port.
REQ-010 o_grant_i  output  1  I-cache owns the memory port.
REQ-011 o_grant_d  output  1  D-cache owns the memory port.
REQ-012 o_timeout  output  1  one-cycle pulse when a transaction is aborted by timeout.
REQ-013 The 66-bit request layout is [65] req, [64] we, [63:32] addr, [31:0] wdata.
REQ-014 The 33-bit response layout is [32] ack, [31:0] rdata.

Function
REQ-015 The FSM has exactly three states: IDLE, GNT_I and GNT_D.
REQ-016 In IDLE, with exactly one req high, the next state is the GNT state of that requester.
REQ-017 In IDLE, with both req high, the next state grants the requester that was not granted last (round-robin); last_grant resets to I, so the D-cache wins the first tie.
REQ-018 last_grant updates on the IDLE-to-GNT transition.
REQ-019 In GNT_x, Mem_bus_out is the granted requester's bus, combinationally.
REQ-020 In IDLE, Mem_bus_out is all zeros.
REQ-021 In GNT_x, Mem_bus_in is passed combinationally to the granted requester's response bus.
REQ-022 The non-granted requester's response is always 33'h0.
REQ-023 Grant latency is one cycle: req sampled high in IDLE at edge N gives a grant from cycle N+1.
REQ-024 In GNT_x, ack=1 completes the transaction: the requester sees ack in the same cycle, and the next state is IDLE.
REQ-025 After each completion there is one mandatory IDLE cycle; back-to-back grants are not allowed.
REQ-026 In GNT_x, if the granted requester drops req without an ack, the transaction aborts: next state IDLE, no o_timeout, and any memory ack in that cycle is not forwarded.
REQ-027 In GNT_x, a wait counter counts cycles without ack; it clears on entry to GNT.
REQ-028 When the wait counter equals TIMEOUT_CYCLES-1 and ack=0, the arbiter drives a synthetic response {1'b1, 32'h0} to the granted requester, pulses o_timeout for that cycle, and goes to IDLE.
REQ-029 If ack and timeout occur in the same cycle, ack wins: real rdata is forwarded and o_timeout stays 0.
REQ-030 The wait counter width is clog2(TIMEOUT_CYCLES+1) bits; it does not wrap, because it clears before overflow.
REQ-031 o_grant_i=1 exactly in GNT_I; o_grant_d=1 exactly in GNT_D; they are never both 1.
REQ-032 A req held by the non-granted requester during a grant is serviced at the next IDLE.

Reset
REQ-033 While Rst=0, the FSM is IDLE, last_grant=I, the wait counter is 0, and o_grant_i, o_grant_d and o_timeout are 0.
REQ-034 While Rst=0, Mem_bus_out is 66'h0 and both response buses are 33'h0, regardless of the inputs.
REQ-035 Reset asserted mid-transaction abandons that transaction with no ack to any requester; it is not resumed after reset.

Structure
REQ-036 A shared package holds the bus field bit positions (REQ/WE/ADDR/WDATA, ACK/RDATA), the request/response widths and the FSM state encoding.
REQ-037 The wait counter and timeout compare are implemented in one sub-module, arb_wdog.

Verification
REQ-038 Single requester: I req=1, addr=0x100, at cycle 0; memory ack at cycle 3 with rdata=0xCAFEF00D -> o_grant_i=1 in cycles 1-3, I response {1,0xCAFEF00D} in cycle 3, IDLE in cycle 4.
REQ-039 Tie after reset: both req=1 at cycle 0 -> GNT_D first; after D completes plus one IDLE cycle -> GNT_I.
REQ-040 Timeout with TIMEOUT_CYCLES=4 and no ack: D granted at cycle 1 -> at cycle 4 D response {1,0x0} and o_timeout=1 for one cycle; IDLE at cycle 5.
REQ-041 Requester abort: I granted, drops req at cycle 2, memory ack=1 at cycle 2 -> I response 0, no o_timeout, IDLE at cycle 3.
REQ-042 Reset mid-grant: Rst=0 asynchronously during GNT_D -> grants, Mem_bus_out and responses go to 0 immediately; after release, a held D req is granted one cycle later.
REQ-043 Ack/timeout collision: ack at wait count TIMEOUT_CYCLES-1 -> real rdata forwarded, o_timeout=0.
